serial_borrow_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor: computes diff = a - b - bin over WIDTH bits, processing one bit per clock, LSB first.
- It is the inverse-operation counterpart to the team's structural ripple-carry adder. It trades WIDTH cycles of latency for a single full-subtractor cell.
- It sits behind a start/ready/valid handshake so a controller or datapath sequencer can issue subtractions and collect results.

---
 rtl/serial_borrow_subtractor.sv | 88 ++++++++
 tb/tb_serial_borrow_subtractor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - bit-serial ripple-borrow subtractor with start/ready/valid handshake
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             valid
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            br;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            a_i, b_i, d_i, br_nx, last;

  // Single full-subtractor cell fed from the LSB of each operand shift register
  assign a_i   = a_sh[0];
  assign b_i   = b_sh[0];
  assign d_i   = a_i ^ b_i ^ br;
  assign br_nx = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last  = (idx == IW'(WIDTH - 1));

  // Handshake outputs decode straight from the state register
  assign ready = (state == IDLE);
  assign valid = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: accept in IDLE, leave RUN after the top bit, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then resolve one bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      br   <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            diff <= '0;
            idx  <= '0;
          end
        end
        RUN: begin
          diff[idx] <= d_i;
          br        <= br_nx;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          idx       <= idx + IW'(1);
          if (last) bout <= br_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb/tb_serial_borrow_subtractor.sv - self-checking bench for serial_borrow_subtractor
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         ready, bout, valid;
  logic [W-1:0] diff;

  logic         start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic         ready1, bout1, valid1, diff1;

  logic         start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0, diff8;
  logic         ready8, bout8, valid8;

  int total = 0;
  int bad   = 0;
  logic [4:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  vec_t vt[5];

  always #5 clk = ~clk;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .diff(diff), .bout(bout), .valid(valid)
  );

  serial_borrow_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .ready(ready1), .diff(diff1), .bout(bout1), .valid(valid1)
  );

  serial_borrow_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .diff(diff8), .bout(bout8), .valid(valid8)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op on the WIDTH=4 instance; expected result goes through the scoreboard
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                        input logic [4:0] exp);
    int n;
    logic [4:0] e;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_wait", 32'(ready), 32'd1);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    check("ready_drop", 32'(ready), 32'd0);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
    n = 1;
    while (!valid && n < W + 4) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (valid) begin
      check("result", 32'({bout, diff}), 32'(e));
      check("latency", 32'(n), 32'(W + 1));
      @(negedge clk);
      check("valid_width", 32'(valid), 32'd0);
      check("ready_back", 32'(ready), 32'd1);
    end else begin
      check("valid_timeout", 32'(valid), 32'd1);
    end
  endtask

  initial begin
    int n, vcount, last_v, ok_cnt;
    logic [3:0] ra, rb;
    logic rbin;
    logic [4:0] e;

    vt[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, ed: 4'd6,  eb: 1'b0};
    vt[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, ed: 4'hA,  eb: 1'b1};
    vt[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ed: 4'hF,  eb: 1'b1};
    vt[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, ed: 4'd0,  eb: 1'b0};
    vt[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, ed: 4'hE,  eb: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_diff",  32'(diff),  32'd0);
    check("rst_bout",  32'(bout),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 5; i++)
      run_op(vt[i].a, vt[i].b, vt[i].bin, {vt[i].eb, vt[i].ed});

    // start held high: one op every W+2 cycles, operand changes during RUN ignored
    sb.delete();
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    vcount = 0; last_v = -1;
    sb.push_back(5'd5);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : 5'h1F;
        check("hold_result", 32'({bout, diff}), 32'(e));
        if (last_v >= 0) check("hold_spacing", 32'(c - last_v), 32'd6);
        last_v = c;
        vcount++;
      end
      if (ready) begin
        a = 4'd7; b = 4'd2; bin = 1'b0;
        sb.push_back(5'd5);
      end else begin
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      end
    end
    check("hold_count", 32'(vcount), 32'd3);
    start = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    sb.delete();

    // Reset in the middle of an operation
    a = 4'd12; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_diff",  32'(diff),  32'd0);
    check("midrst_bout",  32'(bout),  32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("midrst_no_valid", 32'(vcount), 32'd0);
    run_op(4'd12, 4'd5, 1'b0, 5'd7);

    // Exhaustive sweep, compared only on mismatch counts to keep the log short
    ok_cnt = bad;
    for (int i = 0; i < 512; i++) begin
      ra = 4'(i >> 5); rb = 4'(i >> 1); rbin = 1'(i);
      e = 5'({1'b0, ra} - {1'b0, rb} - {4'b0, rbin});
      run_op(ra, rb, rbin, e);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
      e = 5'({1'b0, ra} - {1'b0, rb} - {4'b0, rbin});
      run_op(ra, rb, rbin, e);
    end
    check("sweep_random_clean", 32'(bad - ok_cnt), 32'd0);

    // WIDTH=1 instance
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!valid1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w1_valid", 32'(valid1), 32'd1);
    check("w1_latency", 32'(n), 32'd2);
    check("w1_result", 32'({bout1, diff1}), 32'b11);

    // WIDTH=8 instance
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8_valid", 32'(valid8), 32'd1);
    check("w8_latency", 32'(n), 32'd9);
    check("w8_result", 32'({bout8, diff8}), 32'h1FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
